// File: rtl/sar_avg_buffer.sv
// SAR conversion averager: sums 2^avg_sel accepted samples, floors the mean and
// queues results in a small first-word-fall-through FIFO with sticky drop flag.
module sar_avg_buffer #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          conv_data,
  input  logic                       conv_valid,
  input  logic                       enable,
  input  logic [1:0]                 avg_sel,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  input  logic                       clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = DATA_W + 3;

  logic              r_run;
  logic [SW-1:0]     r_acc;
  logic [2:0]        r_cnt;
  logic [1:0]        r_sel;
  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_fcnt;
  logic              r_ovf;

  logic              w_accept, w_last, w_push, w_pop, w_full, w_wr, w_drop;
  logic [1:0]        w_sel;
  logic [2:0]        w_blk_m1;
  logic [SW-1:0]     w_sum, w_shift;
  logic [DATA_W-1:0] w_result;
  logic [AW-1:0]     w_rp_prev;

  // r_run holds off sample acceptance for the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;

  assign w_accept = conv_valid & enable & r_run;
  assign w_sel    = (r_cnt == 3'd0) ? avg_sel : r_sel;
  assign w_blk_m1 = ~(3'b111 << w_sel);
  assign w_last   = (r_cnt == w_blk_m1);
  assign w_sum    = r_acc + SW'(conv_data);
  assign w_shift  = w_sum >> w_sel;
  assign w_result = w_shift[DATA_W-1:0];
  assign w_push   = w_accept & w_last;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sel <= '0;
    end else if (!enable) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (r_cnt == 3'd0) r_sel <= avg_sel;
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 3'd1;
      end
    end

  assign w_full = (r_fcnt == (AW+1)'(DEPTH));
  assign w_pop  = out_valid & out_ready;
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mem  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= w_result;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        r_ovf <= 1'b0;
    else if (w_drop)   r_ovf <= 1'b1;
    else if (clr_ovf)  r_ovf <= 1'b0;

  // When empty, the slot behind the read pointer still holds the last head
  assign w_rp_prev  = r_rp - 1'b1;
  assign out_valid  = (r_fcnt != '0);
  assign out_data   = out_valid ? r_mem[r_rp] : r_mem[w_rp_prev];
  assign fifo_count = r_fcnt;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_sar_avg_buffer.sv
// Directed bench for sar_avg_buffer: averaging, FIFO full/drop, reset behaviour.
module tb_sar_avg_buffer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] conv_data;
  logic       conv_valid, enable, out_ready, clr_ovf;
  logic [1:0] avg_sel;
  logic [9:0] out_data;
  logic       out_valid, overflow;
  logic [2:0] fifo_count;
  int n_cmp = 0;
  int n_err = 0;

  sar_avg_buffer #(.DATA_W(10), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .conv_data(conv_data), .conv_valid(conv_valid),
    .enable(enable), .avg_sel(avg_sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample(input logic [9:0] d);
    conv_data = d; conv_valid = 1'b1;
    step();
    conv_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; conv_data = '0; conv_valid = 0; enable = 1; out_ready = 1;
    clr_ovf = 0; avg_sel = 0;
    step(); step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(out_data), 0);
    rst_n = 1'b1;
    step(); step();

    // single-sample block, passes straight through
    sample(10'h155);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), 32'h155);
    chk("t1_cnt", 32'(fifo_count), 1);
    step();
    chk("t1_valid_after", 32'(out_valid), 0);
    chk("t1_cnt_after", 32'(fifo_count), 0);
    chk("t1_data_hold", 32'(out_data), 32'h155);

    // four-sample block: 407>>2 = 101
    out_ready = 0; avg_sel = 2;
    sample(100); chk("t2_s1", 32'(fifo_count), 0);
    sample(101); chk("t2_s2", 32'(fifo_count), 0);
    sample(102); chk("t2_s3", 32'(fifo_count), 0);
    sample(104);
    chk("t2_cnt", 32'(fifo_count), 1);
    chk("t2_data", 32'(out_data), 101);
    out_ready = 1; step();
    chk("t2_drain", 32'(fifo_count), 0);

    // overflow: five results into a four-deep FIFO
    out_ready = 0; avg_sel = 0;
    for (int i = 1; i <= 4; i++) sample(10'(i));
    chk("t3_full", 32'(fifo_count), 4);
    chk("t3_ovf0", 32'(overflow), 0);
    sample(5);
    chk("t3_full2", 32'(fifo_count), 4);
    chk("t3_ovf1", 32'(overflow), 1);
    chk("t3_head", 32'(out_data), 1);
    clr_ovf = 1; step(); clr_ovf = 0;
    chk("t3_clr", 32'(overflow), 0);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_pop", 32'(out_data), 32'(i));
      step();
    end
    chk("t3_empty", 32'(out_valid), 0);
    chk("t3_cnt0", 32'(fifo_count), 0);

    // push and pop on the same edge while full
    out_ready = 0;
    for (int i = 1; i <= 4; i++) sample(10'(i));
    conv_data = 9; conv_valid = 1; out_ready = 1;
    step();
    conv_valid = 0; out_ready = 0;
    chk("t4_cnt", 32'(fifo_count), 4);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_head", 32'(out_data), 2);
    out_ready = 1;
    chk("t4_p2", 32'(out_data), 2); step();
    chk("t4_p3", 32'(out_data), 3); step();
    chk("t4_p4", 32'(out_data), 4); step();
    chk("t4_p9", 32'(out_data), 9); step();
    chk("t4_empty", 32'(out_valid), 0);

    // enable low clears partial; avg_sel change mid-block ignored
    out_ready = 0; avg_sel = 3;
    for (int i = 0; i < 3; i++) sample(10'h3FF);
    enable = 0; step(); enable = 1;
    chk("t5_noclear_fifo", 32'(fifo_count), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) avg_sel = 0;
      if (i == 7) chk("t5_pre", 32'(fifo_count), 0);
      sample(10'h010);
    end
    chk("t5_cnt", 32'(fifo_count), 1);
    chk("t5_data", 32'(out_data), 32'h010);
    out_ready = 1; step(); out_ready = 0;
    chk("t5_drain", 32'(fifo_count), 0);

    // drop and clr_ovf on the same edge: set wins
    avg_sel = 0;
    for (int i = 1; i <= 4; i++) sample(10'(i));
    clr_ovf = 1; sample(5); clr_ovf = 0;
    chk("t6_setwins", 32'(overflow), 1);
    out_ready = 1; step(); step(); out_ready = 0;
    chk("t6_cnt2", 32'(fifo_count), 2);
    avg_sel = 1; sample(50);
    // asynchronous reset between edges
    #2 rst_n = 0; #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_cnt", 32'(fifo_count), 0);
    chk("t6_rst_ovf", 32'(overflow), 0);
    chk("t6_rst_data", 32'(out_data), 0);
    step();
    // sample presented on the first edge after release is ignored
    avg_sel = 0; conv_data = 100; conv_valid = 1;
    rst_n = 1;
    step();
    conv_valid = 0;
    chk("t6_rel_ignored", 32'(fifo_count), 0);
    avg_sel = 1;
    sample(6);
    chk("t6_partial", 32'(fifo_count), 0);
    sample(8);
    chk("t6_avg_cnt", 32'(fifo_count), 1);
    chk("t6_avg_data", 32'(out_data), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sar_avg_buffer.md
SAR_AVG_BUFFER -- requirements
Module: sar_avg_buffer

Interface
REQ-001 SHALL provide parameter: DATA_W, 10, width of SAR conversion word and averaged result.
REQ-002 SHALL provide parameter: DEPTH, 4, result FIFO depth in entries (power of two, >=2).
REQ-003 SHALL have port: clk  input  1  single block clock, rising-edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: conv_data  input  DATA_W  completed conversion word from upstream SAR logic.
REQ-006 SHALL have port: conv_valid  input  1  one-cycle pulse, conv_data valid.
REQ-007 SHALL have port: enable  input  1  accumulate enable; low clears the partial block.
REQ-008 SHALL have port: avg_sel  input  2  block size select, 2^avg_sel samples (1,2,4,8).
REQ-009 SHALL have port: out_data  output  DATA_W  FIFO head, averaged result.
REQ-010 SHALL have port: out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts head.
REQ-012 SHALL have port: fifo_count  output  clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-013 SHALL have port: overflow  output  1  sticky, a result was dropped.
REQ-014 SHALL have port: clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-015 One clock domain; all state on rising clk; single asynchronous active-low reset, no other reset.
REQ-016 Accumulator width DATA_W+3; sample counter 3 bits; no accumulator overflow possible.
REQ-017 Sample accepted iff conv_valid=1 and enable=1; otherwise conv_data ignored.
REQ-018 avg_sel latched into sel_q when an accepted sample arrives with counter=0; sel_q governs that whole block; avg_sel changes mid-block have no effect until next block.
REQ-019 Accepted sample with counter < 2^sel_q-1: acc <= acc+conv_data, counter +1.
REQ-020 Accepted sample completing the block (counter = 2^sel_q-1, or sel_q=0): result = (acc+conv_data) >> sel_q, truncated (floor) to DATA_W bits; push result at that same edge; acc and counter <= 0.
REQ-021 Latency: completing sample at edge N -> result visible on out_data with out_valid=1 after edge N when FIFO was empty.
REQ-022 enable=0: acc and counter <= 0 synchronously; FIFO contents, out_valid, overflow unaffected.
REQ-023 FIFO first-word-fall-through: out_data = head whenever out_valid=1; out_data value undefined-but-stable (hold last head) when empty.
REQ-024 out_valid = (fifo_count != 0); pop occurs at edge where out_valid=1 and out_ready=1.
REQ-025 Push when fifo_count < DEPTH: entry written at tail, count +1 (count unchanged if pop same edge).
REQ-026 Push when fifo_count = DEPTH and pop same edge: push accepted, count stays DEPTH, order preserved.
REQ-027 Push when fifo_count = DEPTH and no pop: result dropped, FIFO unchanged, overflow <= 1.
REQ-028 overflow stays 1 until clr_ovf=1 at an edge; drop event and clr_ovf same edge -> overflow = 1 (set wins).
REQ-029 out_ready with empty FIFO: no effect; count never underflows.
REQ-030 Read/write pointers wrap modulo DEPTH.

Reset
REQ-031 rst_n=0 asynchronously forces: acc=0, counter=0, sel_q=0, FIFO empty, fifo_count=0, out_valid=0, out_data=0, overflow=0.
REQ-032 Reset mid-block or mid-FIFO discards partial sum and all stored results; first block after release starts at counter=0.
REQ-033 Release of rst_n synchronous-safe: no sample accepted in the cycle rst_n rises asynchronously.

Verification
REQ-034 avg_sel=0, enable=1, out_ready=1, conv_data=0x155 pulse -> out_data=0x155, out_valid=1 for one cycle after edge, fifo_count returns 0.
REQ-035 avg_sel=2, samples 100,101,102,104 -> single push out_data=101 (407>>2); no push after first three samples.
REQ-036 avg_sel=0, out_ready=0, 5 samples 1..5 with DEPTH=4 -> fifo_count=4, overflow=1, then popping yields 1,2,3,4 in order, out_valid=0 after.
REQ-037 FIFO full, conv_valid and out_ready same cycle -> head 1 popped, new value appended, fifo_count stays 4, overflow stays 0.
REQ-038 avg_sel=3, 3 samples of 0x3FF then enable=0 one cycle, then 8 samples of 0x010 -> single result 0x010; avg_sel changed to 0 after 2nd of these 8 has no effect.
REQ-039 rst_n asserted with 2 entries stored and partial sum pending -> immediately out_valid=0, fifo_count=0, overflow=0; clr_ovf and drop same edge -> overflow=1.
